instr_fetch_queue: RTL and testbench

//  Consumer side of the program counter: walks a word-aligned fetch address, issues
//  in-order read requests to instruction memory, buffers returned words with their PCs
//  in a DEPTH-entry FIFO and hands them to decode over valid/ready. A redirect
//  (branch/jump) flushes the queue and discards in-flight responses.

---
 rtl/instr_fetch_queue.sv | 98 +++++++++
 tb/tb_instr_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches, buffers returned words with their PCs,
// and hands them to decode over valid/ready. A redirect flushes the queue and drops stale responses.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [31:0] memReqAddr,
  input  logic        memRspValid,
  input  logic [31:0] memRspData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] next_outstanding;
  logic [CW:0]   in_use;
  logic [31:0]   target_pc;
  logic          req_fire;
  logic          rsp_dec;
  logic          push;
  logic          pop;

  // Queued plus in-flight words never exceed DEPTH, so a kept response always finds a free slot.
  assign in_use      = {1'b0, count} + {1'b0, outstanding};
  assign memReqValid = reset && !redirect && (in_use < (CW+1)'(DEPTH));
  assign memReqAddr  = fetch_pc;

  assign req_fire         = memReqValid && memReqReady;
  assign rsp_dec          = memRspValid && (outstanding != '0);
  assign next_outstanding = outstanding + CW'(req_fire) - CW'(rsp_dec);
  assign push             = memRspValid && (discard_cnt == '0) && !redirect;
  assign pop              = instrValid && instrReady;
  assign target_pc        = {redirectPc[31:2], 2'b00};

  assign instrValid = (count != '0);
  assign instr      = data_q[rd_ptr];
  assign instrPc    = pc_q[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      // Everything still in flight after this edge belongs to the abandoned path.
      fetch_pc    <= target_pc;
      rsp_pc      <= target_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= next_outstanding;
      discard_cnt <= next_outstanding;
    end else begin
      outstanding <= next_outstanding;
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      if (memRspValid && (discard_cnt != '0))
        discard_cnt <= discard_cnt - 1'b1;
      if (push) begin
        data_q[wr_ptr] <= memRspData;
        pc_q[wr_ptr]   <= rsp_pc;
        wr_ptr         <= wr_ptr + 1'b1;
        rsp_pc         <= rsp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a fixed-latency in-order memory model, a table of per-cycle
// vectors with hand-computed expectations, and hand-written redirect/backpressure/reset sequences.
module tb_instr_fetch_queue;

  typedef struct {
    bit          fresh;
    int          lat;
    logic        mrdy;
    logic        irdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memReqAddr;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirectPc = 32'h0;
  logic        w_memReqValid;
  logic        w_memReqReady = 1'b1;
  logic [31:0] w_memReqAddr;
  logic        w_memRspValid = 1'b0;
  logic [31:0] w_memRspData = 32'h0;
  logic        w_instrValid;
  logic        w_instrReady = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_instrPc;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat_cur = 1;
  rsp_t pend [$];
  vec_t vecs [16];
  logic [31:0] w_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirectPc(redirectPc),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRspValid(memRspValid), .memRspData(memRspData),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc)
  );

  instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_wrap (
    .clk(clk), .reset(reset), .redirect(w_redirect), .redirectPc(w_redirectPc),
    .memReqValid(w_memReqValid), .memReqReady(w_memReqReady), .memReqAddr(w_memReqAddr),
    .memRspValid(w_memRspValid), .memRspData(w_memRspData),
    .instrValid(w_instrValid), .instrReady(w_instrReady), .instr(w_instr), .instrPc(w_instrPc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic mrdy, input logic irdy, input logic redir, input logic [31:0] rpc);
    memReqReady = mrdy;
    instrReady  = irdy;
    redirect    = redir;
    redirectPc  = rpc;
    #1;
  endtask

  task automatic drive_rsp();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      memRspValid = 1'b1;
      memRspData  = mem_word(pend[0].addr);
    end else begin
      memRspValid = 1'b0;
      memRspData  = 32'h0;
    end
  endtask

  // Captures the handshake before the edge, then updates the memory model and drives its response.
  task automatic step();
    logic        fire;
    logic [31:0] faddr;
    fire  = memReqValid && memReqReady;
    faddr = memReqAddr;
    @(posedge clk);
    cyc++;
    if (memRspValid) pend.delete(0);
    if (fire) pend.push_back('{addr: faddr, due: cyc + lat_cur - 1});
    @(negedge clk);
    drive_rsp();
  endtask

  task automatic do_reset(input int lat);
    reset       = 1'b0;
    redirect    = 1'b0;
    memRspValid = 1'b0;
    memRspData  = 32'h0;
    pend.delete();
    lat_cur = lat;
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int          fires;
    logic [31:0] last_addr;

    // Streaming at latency 1, then request-ready toggling every cycle.
    vecs[0]  = '{1, 1, 1, 1, 1, 32'h00, 0, 32'h00};
    vecs[1]  = '{0, 1, 1, 1, 1, 32'h04, 0, 32'h00};
    vecs[2]  = '{0, 1, 1, 1, 1, 32'h08, 1, 32'h00};
    vecs[3]  = '{0, 1, 1, 1, 1, 32'h0C, 1, 32'h04};
    vecs[4]  = '{0, 1, 1, 1, 1, 32'h10, 1, 32'h08};
    vecs[5]  = '{0, 1, 1, 1, 1, 32'h14, 1, 32'h0C};
    vecs[6]  = '{0, 1, 1, 1, 1, 32'h18, 1, 32'h10};
    vecs[7]  = '{0, 1, 1, 1, 1, 32'h1C, 1, 32'h14};
    vecs[8]  = '{1, 1, 1, 1, 1, 32'h00, 0, 32'h00};
    vecs[9]  = '{0, 1, 0, 1, 1, 32'h04, 0, 32'h00};
    vecs[10] = '{0, 1, 1, 1, 1, 32'h04, 1, 32'h00};
    vecs[11] = '{0, 1, 0, 1, 1, 32'h08, 0, 32'h00};
    vecs[12] = '{0, 1, 1, 1, 1, 32'h08, 1, 32'h04};
    vecs[13] = '{0, 1, 0, 1, 1, 32'h0C, 0, 32'h00};
    vecs[14] = '{0, 1, 1, 1, 1, 32'h0C, 1, 32'h08};
    vecs[15] = '{0, 1, 0, 1, 1, 32'h10, 0, 32'h00};

    reset = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    memReqReady = 1'b0; instrReady = 1'b0; memRspValid = 1'b0; memRspData = 32'h0;
    @(negedge clk);
    #1;
    checkOutput("reset memReqValid", memReqValid, 1'b0);
    checkOutput("reset memReqAddr", memReqAddr, 32'h0);
    checkOutput("reset instrValid", instrValid, 1'b0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset instrPc", instrPc, 32'h0);
    checkOutput("wrap reset addr", w_memReqAddr, 32'hFFFF_FFF8);
    checkOutput("wrap reset valid", w_memReqValid, 1'b0);

    // Address wrap from a reset PC near the top of the address space.
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      if (i < 4) begin
        checkOutput($sformatf("wrap addr %0d", i), w_memReqAddr, w_exp[i]);
        checkOutput($sformatf("wrap valid %0d", i), w_memReqValid, 1'b1);
      end else begin
        checkOutput("wrap credit exhausted", w_memReqValid, 1'b0);
      end
      step();
    end

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].fresh) do_reset(vecs[i].lat);
      applyStimulus(vecs[i].mrdy, vecs[i].irdy, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d memReqValid", i), memReqValid, vecs[i].exp_rv);
      checkOutput($sformatf("vec%0d memReqAddr", i), memReqAddr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d instrValid", i), instrValid, vecs[i].exp_iv);
      if (vecs[i].exp_iv) begin
        checkOutput($sformatf("vec%0d instrPc", i), instrPc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d instr", i), instr, mem_word(vecs[i].exp_pc));
      end
      step();
    end

    // Decode stalled at latency 2: exactly DEPTH requests, then fetch resumes at 0x10.
    do_reset(2);
    fires = 0;
    last_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (memReqValid) begin
        fires++;
        last_addr = memReqAddr;
      end
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stall request count", fires, 4);
    checkOutput("stall last addr", last_addr, 32'h0C);
    checkOutput("stall memReqValid", memReqValid, 1'b0);
    checkOutput("stall memReqAddr", memReqAddr, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("stall head pc", instrPc, 32'h0);
    checkOutput("stall credit still full", memReqValid, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resume memReqValid", memReqValid, 1'b1);
    checkOutput("resume memReqAddr", memReqAddr, 32'h10);
    checkOutput("resume head pc", instrPc, 32'h04);

    // Redirect at latency 3 with two requests in flight and two words queued.
    do_reset(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("pre-redirect instrValid", instrValid, 1'b1);
    checkOutput("pre-redirect instrPc", instrPc, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    checkOutput("redirect memReqValid", memReqValid, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("post-redirect flushed", instrValid, 1'b0);
    checkOutput("post-redirect memReqValid", memReqValid, 1'b1);
    checkOutput("post-redirect memReqAddr", memReqAddr, 32'h100);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("discard window instrValid %0d", i), instrValid, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redirect first instrValid", instrValid, 1'b1);
    checkOutput("redirect first instrPc", instrPc, 32'h100);
    checkOutput("redirect first instr", instr, mem_word(32'h100));
    checkOutput("redirect credit full", memReqValid, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("head held instrPc", instrPc, 32'h100);
    checkOutput("head held instr", instr, mem_word(32'h100));
    checkOutput("head held credit", memReqValid, 1'b0);

    // Asynchronous reset with the queue full.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full instrValid", instrValid, 1'b1);
    checkOutput("full memReqValid", memReqValid, 1'b0);
    checkOutput("full head pc", instrPc, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("midreset instrValid", instrValid, 1'b0);
    checkOutput("midreset memReqValid", memReqValid, 1'b0);
    checkOutput("midreset memReqAddr", memReqAddr, 32'h0);
    checkOutput("midreset instr", instr, 32'h0);
    checkOutput("midreset instrPc", instrPc, 32'h0);
    checkOutput("midreset wrap addr", w_memReqAddr, 32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
